// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Busy spans the whole operation; HI/LO update only on completion.
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [31:0] op_a, op_a_nxt;
  logic [31:0] op_b, op_b_nxt;
  logic [2:0]  op, op_nxt;
  logic [31:0] hi_q, hi_nxt;
  logic [31:0] lo_q, lo_nxt;

  logic [63:0] prod_s, prod_u;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b;
  logic [31:0] q_m, r_m, quo, rem;

  assign prod_s = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
  assign prod_u = {32'b0, op_a} * {32'b0, op_b};

  // Divide on magnitudes so 0x80000000 / -1 is well defined.
  assign neg_a = (op == OP_DIV) & op_a[31];
  assign neg_b = (op == OP_DIV) & op_b[31];
  assign mag_a = neg_a ? -op_a : op_a;
  assign mag_b = neg_b ? -op_b : op_b;
  assign q_m   = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
  assign r_m   = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
  assign quo   = (neg_a ^ neg_b) ? -q_m : q_m;
  assign rem   = neg_a ? -r_m : r_m;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 32'd0;
      op_a  <= 32'd0;
      op_b  <= 32'd0;
      op    <= 3'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op_a  <= op_a_nxt;
      op_b  <= op_b_nxt;
      op    <= op_nxt;
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_a_nxt  = op_a;
    op_b_nxt  = op_b;
    op_nxt    = op;
    hi_nxt    = hi_q;
    lo_nxt    = lo_q;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          (MDOp == OP_MULT), (MDOp == OP_MULTU): begin
            op_a_nxt  = A;
            op_b_nxt  = B;
            op_nxt    = MDOp;
            cnt_nxt   = 32'(MULT_CYCLES);
            state_nxt = RUN;
          end
          (MDOp == OP_DIV), (MDOp == OP_DIVU): begin
            op_a_nxt  = A;
            op_b_nxt  = B;
            op_nxt    = MDOp;
            cnt_nxt   = 32'(DIV_CYCLES);
            state_nxt = RUN;
          end
          (MDOp == OP_MTHI): hi_nxt = A;
          (MDOp == OP_MTLO): lo_nxt = A;
          default: ;
        endcase
      end
      RUN: begin
        if (cnt == 32'd1) begin
          state_nxt = IDLE;
          cnt_nxt   = 32'd0;
          unique case (1'b1)
            (op == OP_MULT): {hi_nxt, lo_nxt} = prod_s;
            (op == OP_MULTU): {hi_nxt, lo_nxt} = prod_u;
            (op == OP_DIV), (op == OP_DIVU): begin
              // A zero divisor leaves HI/LO untouched.
              if (op_b != 32'd0) begin
                hi_nxt = rem;
                lo_nxt = quo;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_nxt = cnt - 32'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Busy = (state == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
